// File: rtl/public_axi_rd_arbiter_n.sv
// N-master read arbiter: one requestor at a time owns a full-AXI read channel.
// R beats stream to the owner through a one-entry buffer, with per-beat error checks.
module public_axi_rd_arbiter_n #(
    parameter int                 NUM_M    = 2,
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 64,
    parameter int                 ID_W     = 4,
    parameter int                 LEN_W    = 8,
    parameter int                 PRIO_RR  = 0,
    parameter logic [ADDR_W-1:0]  RST_ADDR = 32'h3000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_M-1:0]          req_valid,
    output logic [NUM_M-1:0]          req_ready,
    input  logic [NUM_M*ADDR_W-1:0]   req_addr,
    input  logic [NUM_M*3-1:0]        req_size,
    input  logic [NUM_M*LEN_W-1:0]    req_len,
    input  logic [NUM_M*2-1:0]        req_burst,
    output logic [NUM_M-1:0]          rsp_valid,
    input  logic [NUM_M-1:0]          rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_last,
    output logic                      rsp_err,
    output logic                      err_sticky,
    input  logic                      io_master_arready,
    output logic                      io_master_arvalid,
    output logic [ADDR_W-1:0]         io_master_araddr,
    output logic [ID_W-1:0]           io_master_arid,
    output logic [LEN_W-1:0]          io_master_arlen,
    output logic [2:0]                io_master_arsize,
    output logic [1:0]                io_master_arburst,
    output logic                      io_master_rready,
    input  logic                      io_master_rvalid,
    input  logic [1:0]                io_master_rresp,
    input  logic [DATA_W-1:0]         io_master_rdata,
    input  logic                      io_master_rlast,
    input  logic [ID_W-1:0]           io_master_rid,
    output logic [1:0]                dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits for ready, and the payload is held stable while valid is high.

    localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t              state;
    logic [GW-1:0]       rr_ptr;
    logic [GW-1:0]       grant;
    logic [GW-1:0]       win;
    logic [GW-1:0]       cand;
    logic                win_found;
    logic [LEN_W:0]      beat_cnt;
    logic                buf_full;
    logic                buf_last;
    logic                buf_err;
    logic [DATA_W-1:0]   buf_data;
    logic                r_hs;
    logic                pop;
    logic                beat_err;

    logic [ADDR_W-1:0]   addr_a  [NUM_M];
    logic [2:0]          size_a  [NUM_M];
    logic [LEN_W-1:0]    len_a   [NUM_M];
    logic [1:0]          burst_a [NUM_M];

    for (genvar i = 0; i < NUM_M; i++) begin : g_unpack
        assign addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign size_a[i]  = req_size[i*3 +: 3];
        assign len_a[i]   = req_len[i*LEN_W +: LEN_W];
        assign burst_a[i] = req_burst[i*2 +: 2];
    end

    // Scan starts at rr_ptr in round-robin mode, at index 0 in fixed mode.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_M; k++) begin
            if (PRIO_RR != 0) cand = GW'((int'(rr_ptr) + k) % NUM_M);
            else              cand = GW'(k);
            if (!win_found && req_valid[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int i = 0; i < NUM_M; i++) begin
            req_ready[i] = rst_n && (state == IDLE) && win_found && (win == GW'(i));
            rsp_valid[i] = buf_full && (grant == GW'(i));
        end
    end

    // The last beat's pop closes the burst, so nothing more is accepted in that cycle.
    assign io_master_rready = (state == DATA) && (!buf_full || (rsp_ready[grant] && !buf_last));
    assign r_hs             = io_master_rready && io_master_rvalid;
    assign pop              = buf_full && rsp_ready[grant];

    assign beat_err = (io_master_rresp != 2'b00)
                    || (io_master_rid != io_master_arid)
                    || (beat_cnt > {1'b0, io_master_arlen})
                    || (io_master_rlast != (beat_cnt == {1'b0, io_master_arlen}));

    assign rsp_data  = buf_data;
    assign rsp_last  = buf_last;
    assign rsp_err   = buf_err;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            grant             <= '0;
            io_master_arvalid <= 1'b0;
            io_master_araddr  <= RST_ADDR;
            io_master_arid    <= '0;
            io_master_arlen   <= '0;
            io_master_arsize  <= '0;
            io_master_arburst <= '0;
            beat_cnt          <= '0;
            buf_full          <= 1'b0;
            buf_last          <= 1'b0;
            buf_err           <= 1'b0;
            buf_data          <= '0;
            err_sticky        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        io_master_araddr  <= addr_a[win];
                        io_master_arsize  <= size_a[win];
                        io_master_arlen   <= len_a[win];
                        io_master_arburst <= burst_a[win];
                        io_master_arid    <= ID_W'(win);
                        io_master_arvalid <= 1'b1;
                        grant             <= win;
                        err_sticky        <= 1'b0;
                        state             <= ADDR;
                    end
                end
                ADDR: begin
                    if (io_master_arready) begin
                        io_master_arvalid <= 1'b0;
                        beat_cnt          <= '0;
                        state             <= DATA;
                        if (PRIO_RR != 0)
                            rr_ptr <= (grant == GW'(NUM_M - 1)) ? '0 : grant + 1'b1;
                    end
                end
                DATA: begin
                    if (pop) buf_full <= 1'b0;
                    if (r_hs) begin
                        buf_full <= 1'b1;
                        buf_data <= io_master_rdata;
                        buf_last <= io_master_rlast;
                        buf_err  <= beat_err;
                        if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
                        if (beat_err) err_sticky <= 1'b1;
                    end
                    if (pop && buf_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_public_axi_rd_arbiter_n.sv
// Directed bench for public_axi_rd_arbiter_n: a fixed-priority instance is checked in
// every scenario, a round-robin instance alongside it for grant ordering.
module tb_public_axi_rd_arbiter_n;

    localparam int NUM_M  = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int ID_W   = 4;
    localparam int LEN_W  = 8;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_M-1:0]         req_valid;
    logic [NUM_M*ADDR_W-1:0]  req_addr;
    logic [NUM_M*3-1:0]       req_size;
    logic [NUM_M*LEN_W-1:0]   req_len;
    logic [NUM_M*2-1:0]       req_burst;
    logic [NUM_M-1:0]         rsp_ready;
    logic                     io_master_arready;
    logic                     io_master_rvalid;
    logic [1:0]               io_master_rresp;
    logic [DATA_W-1:0]        io_master_rdata;
    logic                     io_master_rlast;
    logic [ID_W-1:0]          io_master_rid;

    logic [NUM_M-1:0]  req_ready,  req_ready_rr;
    logic [NUM_M-1:0]  rsp_valid,  rsp_valid_rr;
    logic [DATA_W-1:0] rsp_data,   rsp_data_rr;
    logic              rsp_last,   rsp_last_rr;
    logic              rsp_err,    rsp_err_rr;
    logic              err_sticky, err_sticky_rr;
    logic              arvalid,    arvalid_rr;
    logic [ADDR_W-1:0] araddr,     araddr_rr;
    logic [ID_W-1:0]   arid,       arid_rr;
    logic [LEN_W-1:0]  arlen,      arlen_rr;
    logic [2:0]        arsize,     arsize_rr;
    logic [1:0]        arburst,    arburst_rr;
    logic              rready,     rready_rr;
    logic [1:0]        dbg_state,  dbg_state_rr;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W+1:0] exp_q[$];

    public_axi_rd_arbiter_n #(.NUM_M(NUM_M), .PRIO_RR(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_len(req_len), .req_burst(req_burst),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err), .err_sticky(err_sticky),
        .io_master_arready(io_master_arready), .io_master_arvalid(arvalid),
        .io_master_araddr(araddr), .io_master_arid(arid), .io_master_arlen(arlen),
        .io_master_arsize(arsize), .io_master_arburst(arburst),
        .io_master_rready(rready), .io_master_rvalid(io_master_rvalid),
        .io_master_rresp(io_master_rresp), .io_master_rdata(io_master_rdata),
        .io_master_rlast(io_master_rlast), .io_master_rid(io_master_rid),
        .dbg_state(dbg_state)
    );

    public_axi_rd_arbiter_n #(.NUM_M(NUM_M), .PRIO_RR(1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready_rr), .req_addr(req_addr),
        .req_size(req_size), .req_len(req_len), .req_burst(req_burst),
        .rsp_valid(rsp_valid_rr), .rsp_ready(rsp_ready), .rsp_data(rsp_data_rr),
        .rsp_last(rsp_last_rr), .rsp_err(rsp_err_rr), .err_sticky(err_sticky_rr),
        .io_master_arready(io_master_arready), .io_master_arvalid(arvalid_rr),
        .io_master_araddr(araddr_rr), .io_master_arid(arid_rr), .io_master_arlen(arlen_rr),
        .io_master_arsize(arsize_rr), .io_master_arburst(arburst_rr),
        .io_master_rready(rready_rr), .io_master_rvalid(io_master_rvalid),
        .io_master_rresp(io_master_rresp), .io_master_rdata(io_master_rdata),
        .io_master_rlast(io_master_rlast), .io_master_rid(io_master_rid),
        .dbg_state(dbg_state_rr)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0; req_addr = '0; req_size = '0; req_len = '0; req_burst = '0;
        rsp_ready = '0; io_master_arready = 1'b0; io_master_rvalid = 1'b0;
        io_master_rresp = '0; io_master_rdata = '0; io_master_rlast = 1'b0; io_master_rid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int m, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        req_addr[m*ADDR_W +: ADDR_W] = addr;
        req_len[m*LEN_W +: LEN_W]    = len;
        req_size[m*3 +: 3]           = size;
        req_burst[m*2 +: 2]          = burst;
    endtask

    task automatic start_burst(input int m, input logic [31:0] addr, input logic [7:0] len);
        set_req(m, addr, len, 3'd3, 2'b01);
        req_valid = '0;
        req_valid[m] = 1'b1;
        tick();
        req_valid = '0;
        io_master_arready = 1'b1;
        tick();
        io_master_arready = 1'b0;
    endtask

    // Slave streams nbeats beats (rlast on the final one); every popped response beat is
    // checked against the expected queue. Ends once the last beat is popped.
    task automatic run_burst(input int m, input int nbeats, input logic [63:0] base,
                             input logic [7:0] err_mask, input int resp_err_beat,
                             input bit bad_rid, input bit toggle, input int exp_cycles,
                             input string name);
        int b = 0;
        int cyc = 0;
        int pops = 0;
        bit done = 0;
        logic r_hs, p_hs;
        logic [DATA_W+1:0] got, exp;
        logic [NUM_M-1:0] other;
        exp_q.delete();
        while (!done && cyc < 64) begin
            rsp_ready = '0;
            rsp_ready[m] = toggle ? (cyc % 2 == 1) : 1'b1;
            io_master_rvalid = (b < nbeats);
            io_master_rdata  = base + 64'(b);
            io_master_rlast  = (b == nbeats - 1);
            io_master_rresp  = (b == resp_err_beat) ? 2'b10 : 2'b00;
            io_master_rid    = bad_rid ? 4'd1 : 4'(m);
            #1;
            r_hs = rready && io_master_rvalid;
            p_hs = rsp_valid[m] && rsp_ready[m];
            if (p_hs) begin
                got = {rsp_err, rsp_last, rsp_data};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s extra_beat: got %h, none expected", name, got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL %s beat%0d {err,last,data}: got %h expected %h", name, pops, got, exp);
                    end
                end
                pops++;
                if (rsp_last) done = 1;
            end
            other = rsp_valid;
            other[m] = 1'b0;
            n_checks++;
            if (other !== '0) begin
                n_fail++;
                $display("FAIL %s rsp_valid_other: got %b expected 0", name, rsp_valid);
            end
            if (r_hs) begin
                exp_q.push_back({err_mask[3'(b)], (b == nbeats - 1), base + 64'(b)});
                b++;
            end
            tick();
            cyc++;
        end
        io_master_rvalid = 1'b0;
        io_master_rlast  = 1'b0;
        io_master_rresp  = 2'b00;
        rsp_ready = '0;
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL %s timeout: got no last beat in %0d cycles", name, cyc); end
        n_checks++;
        if (pops != nbeats) begin n_fail++; $display("FAIL %s beat_count: got %0d expected %0d", name, pops, nbeats); end
        n_checks++;
        if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL %s end_state: got %0d expected 0", name, dbg_state); end
        if (exp_cycles > 0) begin
            n_checks++;
            if (cyc != exp_cycles) begin n_fail++; $display("FAIL %s cycles: got %0d expected %0d", name, cyc, exp_cycles); end
        end
    endtask

    // Scenarios
    task automatic test_reset();
        logic [127:0] got, exp;
        got = {arvalid, araddr, arid, arlen, arsize, arburst, rready, rsp_valid, rsp_data,
               rsp_last, rsp_err, err_sticky, req_ready, dbg_state};
        exp = {1'b0, 32'h3000_0000, 4'd0, 8'd0, 3'd0, 2'd0, 1'b0, 2'b00, 64'd0,
               1'b0, 1'b0, 1'b0, 2'b00, 2'd0};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", got, exp); end
    endtask

    task automatic test_single_read();
        set_req(0, 32'h8000_0000, 8'd0, 3'd3, 2'b01);
        req_valid = 2'b01;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single req_ready: got %b expected 01", req_ready); end
        n_checks++;
        if (arvalid !== 1'b0) begin n_fail++; $display("FAIL single arvalid_early: got %b expected 0", arvalid); end
        tick();
        req_valid = '0;
        n_checks++;
        if ({arvalid, araddr, arid, arlen, arsize, dbg_state} !== {1'b1, 32'h8000_0000, 4'd0, 8'd0, 3'd3, 2'd1}) begin
            n_fail++;
            $display("FAIL single ar_fields: got %b %h %h %h %h %h expected 1 80000000 0 00 3 1",
                     arvalid, araddr, arid, arlen, arsize, dbg_state);
        end
        io_master_arready = 1'b1;
        tick();
        io_master_arready = 1'b0;
        n_checks++;
        if ({arvalid, dbg_state} !== {1'b0, 2'd2}) begin
            n_fail++; $display("FAIL single to_data: got %b %0d expected 0 2", arvalid, dbg_state);
        end
        run_burst(0, 1, 64'hDEAD_BEEF_0000_0001, 8'h00, -1, 0, 0, 2, "single");
        n_checks++;
        if ({rsp_valid, rsp_data} !== {2'b00, 64'hDEAD_BEEF_0000_0001}) begin
            n_fail++; $display("FAIL single data_hold: got %b %h expected 00 deadbeef00000001", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_burst4();
        start_burst(1, 32'h8000_1000, 8'd3);
        run_burst(1, 4, 64'h1111_0000_0000_0000, 8'h00, -1, 0, 0, 5, "burst4");
    endtask

    task automatic test_burst_toggle();
        start_burst(1, 32'h8000_2000, 8'd3);
        run_burst(1, 4, 64'h2222_0000_0000_0010, 8'h00, -1, 0, 1, 0, "burst_toggle");
    endtask

    task automatic test_priority();
        logic [1:0] exp_rr_ready;
        logic [3:0] exp_rr_id;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            exp_rr_ready = (r == 1) ? 2'b10 : 2'b01;
            exp_rr_id    = (r == 1) ? 4'd1 : 4'd0;
            set_req(0, 32'h9000_0000, 8'd0, 3'd3, 2'b01);
            set_req(1, 32'h9100_0000, 8'd0, 3'd3, 2'b01);
            req_valid = 2'b11;
            #1;
            n_checks++;
            if ({req_ready, req_ready_rr} !== {2'b01, exp_rr_ready}) begin
                n_fail++; $display("FAIL prio round%0d req_ready fixed/rr: got %b/%b expected 01/%b", r, req_ready, req_ready_rr, exp_rr_ready);
            end
            tick();
            req_valid = '0;
            n_checks++;
            if ({arid, arid_rr} !== {4'd0, exp_rr_id}) begin
                n_fail++; $display("FAIL prio round%0d arid fixed/rr: got %0d/%0d expected 0/%0d", r, arid, arid_rr, exp_rr_id);
            end
            io_master_arready = 1'b1;
            tick();
            io_master_arready = 1'b0;
            io_master_rvalid = 1'b1; io_master_rlast = 1'b1; io_master_rid = '0;
            rsp_ready = 2'b11;
            tick();
            io_master_rvalid = 1'b0; io_master_rlast = 1'b0;
            tick();
            rsp_ready = '0;
            n_checks++;
            if ({dbg_state, dbg_state_rr} !== 4'd0) begin
                n_fail++; $display("FAIL prio round%0d idle fixed/rr: got %0d/%0d expected 0/0", r, dbg_state, dbg_state_rr);
            end
        end
    endtask

    task automatic test_errors();
        start_burst(0, 32'hA000_0000, 8'd3);
        run_burst(0, 4, 64'h3333_0000_0000_0000, 8'b0000_0100, 2, 0, 0, 5, "err_rresp");
        repeat (3) tick();
        n_checks++;
        if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL err_sticky_held: got %b expected 1", err_sticky); end
        set_req(0, 32'hA000_1000, 8'd0, 3'd3, 2'b01);
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        n_checks++;
        if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL err_sticky_clear_on_grant: got %b expected 0", err_sticky); end
        io_master_arready = 1'b1;
        tick();
        io_master_arready = 1'b0;
        run_burst(0, 1, 64'h4444_0000_0000_0000, 8'b0000_0001, -1, 1, 0, 2, "err_rid");
        n_checks++;
        if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL err_sticky_rid: got %b expected 1", err_sticky); end
        start_burst(1, 32'hA000_2000, 8'd3);
        run_burst(1, 2, 64'h5555_0000_0000_0000, 8'b0000_0010, -1, 0, 0, 3, "err_early_last");
        start_burst(0, 32'hA000_3000, 8'd1);
        run_burst(0, 4, 64'h6666_0000_0000_0000, 8'b0000_1110, -1, 0, 0, 5, "err_overrun");
    endtask

    task automatic test_ar_backpressure();
        set_req(1, 32'h1234_5678, 8'd2, 3'd3, 2'b01);
        req_valid = 2'b10;
        tick();
        set_req(0, 32'h0BAD_0000, 8'd7, 3'd2, 2'b00);
        req_valid = 2'b11;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if ({arvalid, araddr, arid, arlen, req_ready} !== {1'b1, 32'h1234_5678, 4'd1, 8'd2, 2'b00}) begin
                n_fail++;
                $display("FAIL ar_stall cycle%0d: got %b %h %0d %0d %b expected 1 12345678 1 2 00",
                         c, arvalid, araddr, arid, arlen, req_ready);
            end
            tick();
        end
        req_valid = '0;
        io_master_arready = 1'b1;
        tick();
        io_master_arready = 1'b0;
        run_burst(1, 3, 64'h7777_0000_0000_0000, 8'h00, -1, 0, 0, 4, "ar_stall_data");
    endtask

    task automatic test_async_reset();
        start_burst(0, 32'h4000_0000, 8'd3);
        rsp_ready = 2'b01;
        io_master_rvalid = 1'b1; io_master_rlast = 1'b0; io_master_rid = '0; io_master_rresp = '0;
        io_master_rdata = 64'hA0;
        tick();
        io_master_rdata = 64'hA1;
        tick();
        io_master_rdata = 64'hA2;
        n_checks++;
        if ({rsp_valid, rsp_data} !== {2'b01, 64'hA1}) begin
            n_fail++; $display("FAIL areset precondition: got %b %h expected 01 a1", rsp_valid, rsp_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({arvalid, araddr, arid, arlen, rready, rsp_valid, rsp_data, rsp_last, rsp_err, err_sticky, req_ready, dbg_state}
            !== {1'b0, 32'h3000_0000, 4'd0, 8'd0, 1'b0, 2'b00, 64'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0}) begin
            n_fail++;
            $display("FAIL areset outputs: got %b %h %h %h %b %b %h %b %b %b %b %0d expected all reset values",
                     arvalid, araddr, arid, arlen, rready, rsp_valid, rsp_data, rsp_last, rsp_err, err_sticky, req_ready, dbg_state);
        end
        io_master_rvalid = 1'b0;
        rsp_ready = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        start_burst(1, 32'h5000_0000, 8'd0);
        run_burst(1, 1, 64'h8888_0000_0000_0001, 8'h00, -1, 0, 0, 2, "after_reset");
    endtask

    initial begin
        do_reset();
        test_reset();
        test_single_read();
        test_burst4();
        test_burst_toggle();
        test_priority();
        test_errors();
        test_ar_backpressure();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/public_axi_rd_arbiter_n.md
Name: public_axi_rd_arbiter_n

Overview:
- Parametrised N-master read arbiter. Multiplexes NUM_M read requestors (IFU, LSU, future DMA/cache refill) onto one full-AXI read channel toward the SoC bus.
- Adds capabilities the previous arbiter lacked:
  - per-request burst length and burst type;
  - fixed or round-robin priority;
  - beat-by-beat streaming through a one-entry output buffer, at full throughput;
  - per-beat error reporting, including rlast/length consistency.

Parameters:
- NUM_M, 2: number of requestors; index 0 has the highest fixed priority.
- ADDR_W, 32: address width.
- DATA_W, 64: data width.
- ID_W, 4: AXI ID width; must satisfy 2^ID_W >= NUM_M.
- LEN_W, 8: burst length field width (AXI arlen).
- PRIO_RR, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- RST_ADDR, 32'h3000_0000: reset value of araddr.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_M  per-master address valid.
- req_ready  out  NUM_M  per-master address accepted.
- req_addr  in  NUM_M*ADDR_W  packed; master i occupies slice [i*ADDR_W +: ADDR_W].
- req_size  in  NUM_M*3  packed AXI size.
- req_len  in  NUM_M*LEN_W  packed; beats minus 1.
- req_burst  in  NUM_M*2  packed AXI burst type.
- rsp_valid  out  NUM_M  one-hot; set only for the owning master.
- rsp_ready  in  NUM_M  per-master data ready.
- rsp_data  out  DATA_W  shared response data.
- rsp_last  out  1  last beat of the burst.
- rsp_err  out  1  error flag for the current beat.
- err_sticky  out  1  set on any erroneous beat; cleared on the next grant.
- AXI AR channel: io_master_arready in 1, io_master_arvalid out 1, io_master_araddr out ADDR_W, io_master_arid out ID_W, io_master_arlen out LEN_W, io_master_arsize out 3, io_master_arburst out 2.
- AXI R channel: io_master_rready out 1, io_master_rvalid in 1, io_master_rresp in 2, io_master_rdata in DATA_W, io_master_rlast in 1, io_master_rid in ID_W.

Behaviour:
- Reset (async assert, sync deassert handled by the top level):
  - state = IDLE; rr_ptr = 0; grant = 0;
  - araddr = RST_ADDR; arid/arlen/arsize/arburst = 0;
  - output buffer empty; beat_cnt = 0; err_sticky = 0;
  - all valid/ready outputs = 0; rsp_data = 0.
- Reset mid-burst: the transaction is abandoned with no further output.
- States are IDLE, ADDR, DATA.
- IDLE:
  - Winner w = highest-priority master with req_valid.
    - Fixed mode: lowest index.
    - RR mode: first valid index at or after rr_ptr, wrapping at NUM_M.
  - req_ready[i] = IDLE & (i == w) & req_valid[w]. Other masters see ready = 0.
  - On handshake, register:
    - araddr/arsize/arlen/arburst from slice w;
    - arid = w, zero-extended;
    - grant = w;
    - err_sticky = 0.
  - Next state is ADDR. Address latency is 1 cycle from handshake to arvalid.
- ADDR:
  - arvalid = 1. All AR fields are held stable until arready.
  - On arready: state goes to DATA and beat_cnt = 0.
  - In RR mode, rr_ptr = (grant+1) mod NUM_M at this point.
- DATA:
  - io_master_rready = ~buf_full | rsp_ready[grant].
  - An R handshake loads the buffer with:
    - rdata;
    - rlast;
    - err = (rresp != 0) | (rid != arid) | (rlast != (beat_cnt == arlen)).
  - On an R handshake, beat_cnt increments (LEN_W+1 bits, no wrap).
  - rsp_valid[grant] = buf_full; rsp_data, rsp_last and rsp_err come from the buffer.
  - Simultaneous pop and push: the buffer is replaced in the same cycle, giving 1 beat/cycle. Latency is 1 cycle from R handshake to rsp_valid.
  - When the popped beat has rsp_last = 1, state goes to IDLE. In that cycle rready is forced 0, and no new grant occurs until IDLE.
  - A burst with beats beyond arlen before rlast flags err on every such beat and keeps streaming until rlast.
  - Any beat with err sets err_sticky.
- Unused fields: rsp_data holds its last value when not valid.

Test Plan:
- Single read: NUM_M=2. m0 requests addr 0x8000_0000, len 0, size 3. Slave returns rdata 0xDEAD_BEEF_0000_0001 with rlast.
  - Expect arvalid 1 cycle after req handshake, with arid 0.
  - Expect rsp_valid[0] with rsp_last=1 and rsp_err=0; state returns to IDLE.
- 4-beat burst: m1 requests len 3, burst INCR. rvalid held high and rsp_ready held high.
  - Expect 4 consecutive rsp_valid[1] beats with no bubbles; rsp_last on the 4th only.
  - With rsp_ready toggling, no beat is lost or duplicated.
- Priority: m0 and m1 assert req_valid in the same cycle.
  - PRIO_RR=0: m0 wins twice in a row.
  - PRIO_RR=1: grants alternate m0, m1, m0.
- Errors:
  - rresp = 2'b10 on beat 2 of 4: rsp_err=1 on that beat only; err_sticky stays 1 until the next grant.
  - rid = 1 on an arid=0 burst: rsp_err=1.
  - Early rlast at beat 1 of len 3: rsp_err=1 on that beat, then return to IDLE.
- Back-pressure on AR: arready held low for 5 cycles.
  - araddr, arid and arlen remain stable; req_ready stays 0 for all masters.
- Async reset: rst_n asserted during beat 2 of a burst.
  - All outputs go to their reset values immediately, without a clock edge.
  - After release, a new request completes normally.
